signal_conflict_monitor: RTL and testbench
==========================================

SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 3, minimum cycles a vehicle yellow SHALL be shown before red.
REQ-002 Parameter MIN_RED_CLEAR, default 1, minimum consecutive all-red cycles SHALL separate one direction's non-red from the other's green.
REQ-003 Parameter PERSIST, default 2, consecutive cycles a steady-state fault condition SHALL hold before latching.
REQ-004 Parameter STARTUP_CYC, default 4, consecutive all-red cycles SHALL be required before monitoring begins.
REQ-005 Port clk  input  1  single system clock, rising-edge active.
REQ-006 Port reset  input  1  reset, asynchronous and active-low.
REQ-007 Ports NS_light, EW_light  input  3 each  vehicle heads: 100 red, 010 yellow, 001 green.
REQ-008 Ports NS_ped_light, EW_ped_light  input  3 each  pedestrian heads: 100 don't-walk, 001 walk.
REQ-009 Port clear_fault  input  1  operator clear request, level-sampled each cycle.
REQ-010 Port monitor_ok  output  1  high only in MONITOR state.
REQ-011 Port flash_enable  output  1  high in FAULT state; commands intersection to red flash.
REQ-012 Port fault_code  output  3  latched cause, 0 when no fault.
REQ-013 Port fault_count  output  8  number of faults latched since reset, saturating at 255.

Function
REQ-014 All outputs SHALL be registered; a condition present at rising edge N SHALL be visible on outputs after edge N.
REQ-015 FSM states SHALL be STARTUP, MONITOR, FAULT.
REQ-016 STARTUP: all-red counter increments while NS_light=EW_light=100 and both ped lights=100, else clears to 0; SHALL go to MONITOR when counter reaches STARTUP_CYC.
REQ-017 MONITOR: first detected fault SHALL move to FAULT, load fault_code, increment fault_count (saturating).
REQ-018 FAULT: SHALL remain until clear_fault=1 while all heads red; then SHALL go to STARTUP with fault_code cleared to 0.
REQ-019 Code 1 conflict: NS_light!=100 and EW_light!=100 for PERSIST consecutive cycles.
REQ-020 Code 2 invalid: any vehicle head outside {100,010,001} or any ped head outside {100,001} for PERSIST consecutive cycles.
REQ-021 Code 3 ped conflict: a ped head=001 while its own vehicle head!=001 or cross vehicle head!=100, for PERSIST consecutive cycles.
REQ-022 Code 4 skipped yellow: a vehicle head changes 001 to 100 in one cycle; latched immediately.
REQ-023 Code 5 short yellow: head changes 010 to 100 after fewer than MIN_YELLOW consecutive yellow cycles; latched immediately.
REQ-024 Code 6 red clearance: head changes 100 to 001 when the last non-red direction was the other one and fewer than MIN_RED_CLEAR all-red cycles immediately preceded; latched immediately.
REQ-025 Yellow counters (per direction) SHALL reset to 1 on entering yellow, increment while yellow, saturate at 255.
REQ-026 Last-non-red direction SHALL be recorded each cycle a head is non-red, and set to none on entry to MONITOR.
REQ-027 Each persistence counter SHALL clear whenever its condition is absent for a cycle.
REQ-028 Simultaneous causes SHALL latch the lowest code number.
REQ-029 Faults SHALL NOT be detected in STARTUP or FAULT; fault_code SHALL not change while in FAULT.
REQ-030 clear_fault while any head non-red SHALL be ignored.

Reset
REQ-031 reset low SHALL immediately force STARTUP, monitor_ok=0, flash_enable=0, fault_code=0, fault_count=0, and clear all counters and history, including mid-fault.
REQ-032 Upon reset release, STARTUP_CYC all-red cycles SHALL be required before monitor_ok=1.

Verification
REQ-033 Release reset, all red 4 cycles -> monitor_ok=1 after 4th edge; legal NS 001 x5, 010 x3, all-red x1, EW 001 -> no fault, fault_count=0.
REQ-034 In MONITOR, NS=001 and EW=001 for 2 cycles -> flash_enable=1, fault_code=1, fault_count=1; 1-cycle overlap only -> no fault.
REQ-035 NS 001 then 100 next cycle -> fault_code=4; NS 010 for 2 cycles then 100 -> fault_code=5.
REQ-036 NS 010 to 100 then EW 001 next cycle with zero all-red cycles (MIN_RED_CLEAR=1) -> fault_code=6; NS_light=011 for 2 cycles -> fault_code=2.
REQ-037 In FAULT, clear_fault=1 with EW=001 -> stays FAULT; all red + clear_fault -> STARTUP, fault_code=0, fault_count retained, monitor_ok after 4 cycles.
REQ-038 Assert reset low mid-FAULT between clock edges -> outputs 0 immediately, fault_count=0.

Source files
------------

// File: rtl/signal_conflict_monitor_if.sv
// Signal-head inputs and monitor status outputs of the intersection conflict monitor.
// The controller/bench side is the master; the monitor is the slave.
interface signal_conflict_monitor_if;
  logic [2:0] NS_light;
  logic [2:0] EW_light;
  logic [2:0] NS_ped_light;
  logic [2:0] EW_ped_light;
  logic       clear_fault;
  logic       monitor_ok;
  logic       flash_enable;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  modport master (
    output NS_light, EW_light, NS_ped_light, EW_ped_light, clear_fault,
    input  monitor_ok, flash_enable, fault_code, fault_count
  );

  modport slave (
    input  NS_light, EW_light, NS_ped_light, EW_ped_light, clear_fault,
    output monitor_ok, flash_enable, fault_code, fault_count
  );
endinterface

// File: rtl/signal_conflict_monitor.sv
// Watches NS/EW vehicle and pedestrian heads for conflicts and sequencing errors,
// latches the first fault and commands red flash until an all-red operator clear.
module signal_conflict_monitor #(
  parameter int unsigned MIN_YELLOW    = 3,
  parameter int unsigned MIN_RED_CLEAR = 1,
  parameter int unsigned PERSIST       = 2,
  parameter int unsigned STARTUP_CYC   = 4
) (
  input logic                     clk,
  input logic                     reset,
  signal_conflict_monitor_if.slave bus
);

  localparam int unsigned CW = 8;
  localparam logic [2:0]    RED  = 3'b100;
  localparam logic [2:0]    YEL  = 3'b010;
  localparam logic [2:0]    GRN  = 3'b001;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {ST_STARTUP, ST_MONITOR, ST_FAULT} state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_NS, DIR_EW} dir_e;

  state_e        state_q;
  dir_e          last_dir_q, last_dir_d;
  logic [2:0]    ns_prev_q, ew_prev_q;
  logic [CW-1:0] startup_cnt_q, startup_cnt_d;
  logic [CW-1:0] ns_yel_q, ns_yel_d, ew_yel_q, ew_yel_d;
  logic [CW-1:0] red_run_q, red_run_d;
  logic [CW-1:0] conf_cnt_q, conf_cnt_d;
  logic [CW-1:0] inv_cnt_q, inv_cnt_d;
  logic [CW-1:0] ped_cnt_q, ped_cnt_d;
  logic          monitor_ok_q, flash_q;
  logic [2:0]    code_q;
  logic [CW-1:0] count_q;

  logic [2:0] ns, ew, nsp, ewp;
  logic       all_red_c, all_heads_red_c, in_mon_c;
  logic       conflict_c, invalid_c, pedconf_c;
  logic       skip_c, short_c, clear6_c;
  logic [2:0] code_c;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CMAX) ? x : x + CW'(1);
  endfunction

  function automatic logic veh_ok(input logic [2:0] h);
    return (h == RED) || (h == YEL) || (h == GRN);
  endfunction

  function automatic logic ped_ok(input logic [2:0] h);
    return (h == RED) || (h == GRN);
  endfunction

  assign ns  = bus.NS_light;
  assign ew  = bus.EW_light;
  assign nsp = bus.NS_ped_light;
  assign ewp = bus.EW_ped_light;

  // Per-cycle fault conditions and next values of the history counters.
  always_comb begin
    all_red_c       = (ns == RED) && (ew == RED);
    all_heads_red_c = all_red_c && (nsp == RED) && (ewp == RED);
    in_mon_c        = (state_q == ST_MONITOR);

    conflict_c = (ns != RED) && (ew != RED);
    invalid_c  = !veh_ok(ns) || !veh_ok(ew) || !ped_ok(nsp) || !ped_ok(ewp);
    pedconf_c  = ((nsp == GRN) && ((ns != GRN) || (ew != RED))) ||
                 ((ewp == GRN) && ((ew != GRN) || (ns != RED)));

    skip_c  = ((ns_prev_q == GRN) && (ns == RED)) ||
              ((ew_prev_q == GRN) && (ew == RED));
    short_c = ((ns_prev_q == YEL) && (ns == RED) && (32'(ns_yel_q) < MIN_YELLOW)) ||
              ((ew_prev_q == YEL) && (ew == RED) && (32'(ew_yel_q) < MIN_YELLOW));
    // Green onset after the cross street without enough all-red before it.
    clear6_c = (32'(red_run_q) < MIN_RED_CLEAR) &&
               (((ns_prev_q == RED) && (ns == GRN) && (last_dir_q == DIR_EW)) ||
                ((ew_prev_q == RED) && (ew == GRN) && (last_dir_q == DIR_NS)));

    conf_cnt_d = (in_mon_c && conflict_c) ? sat_inc(conf_cnt_q) : '0;
    inv_cnt_d  = (in_mon_c && invalid_c)  ? sat_inc(inv_cnt_q)  : '0;
    ped_cnt_d  = (in_mon_c && pedconf_c)  ? sat_inc(ped_cnt_q)  : '0;

    ns_yel_d = (ns != YEL) ? '0 : ((ns_prev_q == YEL) ? sat_inc(ns_yel_q) : CW'(1));
    ew_yel_d = (ew != YEL) ? '0 : ((ew_prev_q == YEL) ? sat_inc(ew_yel_q) : CW'(1));

    red_run_d     = all_red_c ? sat_inc(red_run_q) : '0;
    startup_cnt_d = all_heads_red_c ? sat_inc(startup_cnt_q) : '0;

    last_dir_d = last_dir_q;
    if ((ns != RED) && (ew == RED)) begin
      last_dir_d = DIR_NS;
    end else if ((ew != RED) && (ns == RED)) begin
      last_dir_d = DIR_EW;
    end

    code_c = 3'd0;
    if (32'(conf_cnt_d) >= PERSIST) begin
      code_c = 3'd1;
    end else if (32'(inv_cnt_d) >= PERSIST) begin
      code_c = 3'd2;
    end else if (32'(ped_cnt_d) >= PERSIST) begin
      code_c = 3'd3;
    end else if (skip_c) begin
      code_c = 3'd4;
    end else if (short_c) begin
      code_c = 3'd5;
    end else if (clear6_c) begin
      code_c = 3'd6;
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_STARTUP;
      last_dir_q    <= DIR_NONE;
      ns_prev_q     <= RED;
      ew_prev_q     <= RED;
      startup_cnt_q <= '0;
      ns_yel_q      <= '0;
      ew_yel_q      <= '0;
      red_run_q     <= '0;
      conf_cnt_q    <= '0;
      inv_cnt_q     <= '0;
      ped_cnt_q     <= '0;
      monitor_ok_q  <= 1'b0;
      flash_q       <= 1'b0;
      code_q        <= 3'd0;
      count_q       <= '0;
    end else begin
      ns_prev_q  <= ns;
      ew_prev_q  <= ew;
      ns_yel_q   <= ns_yel_d;
      ew_yel_q   <= ew_yel_d;
      red_run_q  <= red_run_d;
      conf_cnt_q <= conf_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      ped_cnt_q  <= ped_cnt_d;
      last_dir_q <= last_dir_d;

      unique case (state_q)
        ST_STARTUP: begin
          startup_cnt_q <= startup_cnt_d;
          if (32'(startup_cnt_d) >= STARTUP_CYC) begin
            state_q      <= ST_MONITOR;
            monitor_ok_q <= 1'b1;
            last_dir_q   <= DIR_NONE;
          end
        end
        ST_MONITOR: begin
          if (code_c != 3'd0) begin
            state_q      <= ST_FAULT;
            monitor_ok_q <= 1'b0;
            flash_q      <= 1'b1;
            code_q       <= code_c;
            count_q      <= sat_inc(count_q);
          end
        end
        ST_FAULT: begin
          if (bus.clear_fault && all_heads_red_c) begin
            state_q       <= ST_STARTUP;
            flash_q       <= 1'b0;
            code_q        <= 3'd0;
            startup_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_STARTUP;
        end
      endcase
    end
  end

  assign bus.monitor_ok   = monitor_ok_q;
  assign bus.flash_enable = flash_q;
  assign bus.fault_code   = code_q;
  assign bus.fault_count  = count_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed scoreboard bench for signal_conflict_monitor: each stimulus cycle queues
// its expected outputs and an independent monitor pops and compares them.
module tb_signal_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] X = 3'b011;

  typedef struct {
    logic       ok;
    logic       fl;
    logic [2:0] code;
    logic [7:0] cnt;
    string      nm;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  event chk_ev;

  signal_conflict_monitor_if bus();

  signal_conflict_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string field, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, exp);
    end
  endtask

  // Monitor: compares outputs #1 after each active edge or after an async event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.nm, "monitor_ok",   int'(bus.monitor_ok),   int'(e.ok));
        cmp(e.nm, "flash_enable", int'(bus.flash_enable), int'(e.fl));
        cmp(e.nm, "fault_code",   int'(bus.fault_code),   int'(e.code));
        cmp(e.nm, "fault_count",  int'(bus.fault_count),  int'(e.cnt));
      end
    end
  end

  task automatic push(input logic ok, input logic fl, input logic [2:0] code,
                      input logic [7:0] cnt, input string nm);
    exp_t e;
    e.ok = ok; e.fl = fl; e.code = code; e.cnt = cnt; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] ns, input logic [2:0] ew,
                       input logic [2:0] nsp, input logic [2:0] ewp, input logic clr);
    bus.NS_light     = ns;
    bus.EW_light     = ew;
    bus.NS_ped_light = nsp;
    bus.EW_ped_light = ewp;
    bus.clear_fault  = clr;
  endtask

  // One clock of stimulus with the outputs expected after the following edge.
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic [2:0] nsp,
                      input logic clr, input logic ok, input logic fl,
                      input logic [2:0] code, input logic [7:0] cnt, input string nm);
    @(negedge clk);
    drive(ns, ew, nsp, R, clr);
    push(ok, fl, code, cnt, nm);
  endtask

  task automatic release_and_start(input string nm);
    @(negedge clk);
    reset = 1'b1;
    drive(R, R, R, R, 1'b0);
    push(1'b0, 1'b0, 3'd0, 8'd0, {nm, "_s1"});
    step(R, R, R, 0, 0, 0, 0, 0, {nm, "_s2"});
    step(R, R, R, 0, 0, 0, 0, 0, {nm, "_s3"});
    step(R, R, R, 0, 1, 0, 0, 0, {nm, "_s4"});
  endtask

  task automatic clear_and_restart(input logic [7:0] cnt, input string nm);
    step(R, R, R, 1, 0, 0, 0, cnt, {nm, "_clr"});
    for (int i = 0; i < 3; i++) step(R, R, R, 0, 0, 0, 0, cnt, {nm, "_st"});
    step(R, R, R, 0, 1, 0, 0, cnt, {nm, "_mon"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    drive(R, R, R, R, 1'b0);
    #3;
    push(0, 0, 0, 0, "reset");
    -> chk_ev;
    repeat (2) @(posedge clk);

    // Startup then a legal NS-to-EW hand-over.
    release_and_start("startup");
    for (int i = 0; i < 5; i++) step(G, R, R, 0, 1, 0, 0, 0, "ns_green");
    for (int i = 0; i < 3; i++) step(Y, R, R, 0, 1, 0, 0, 0, "ns_yellow");
    step(R, R, R, 0, 1, 0, 0, 0, "allred");
    step(R, G, R, 0, 1, 0, 0, 0, "ew_green");
    step(R, G, R, 0, 1, 0, 0, 0, "ew_green2");
    for (int i = 0; i < 3; i++) step(R, Y, R, 0, 1, 0, 0, 0, "ew_yellow");
    step(R, R, R, 0, 1, 0, 0, 0, "allred2");

    // Single-cycle overlap is tolerated; two cycles latch a conflict.
    for (int i = 0; i < 3; i++) step(Y, R, R, 0, 1, 0, 0, 0, "ns_y_long");
    step(Y, Y, R, 0, 1, 0, 0, 0, "overlap1");
    step(R, Y, R, 0, 1, 0, 0, 0, "ew_y1");
    step(R, Y, R, 0, 1, 0, 0, 0, "ew_y2");
    step(R, R, R, 0, 1, 0, 0, 0, "allred3");
    step(G, G, R, 0, 1, 0, 0, 0, "conflict1");
    step(G, G, R, 0, 0, 1, 1, 1, "conflict2");

    // Clear is ignored while a head is non-red.
    step(R, G, R, 1, 0, 1, 1, 1, "clr_ignored");
    clear_and_restart(8'd1, "c1");

    step(G, R, R, 0, 1, 0, 0, 1, "skip_g");
    step(R, R, R, 0, 0, 1, 4, 2, "skip_yellow");
    clear_and_restart(8'd2, "c4");

    step(Y, R, R, 0, 1, 0, 0, 2, "short_y1");
    step(Y, R, R, 0, 1, 0, 0, 2, "short_y2");
    step(R, R, R, 0, 0, 1, 5, 3, "short_yellow");
    clear_and_restart(8'd3, "c5");

    step(G, R, R, 0, 1, 0, 0, 3, "rc_g");
    for (int i = 0; i < 3; i++) step(Y, R, R, 0, 1, 0, 0, 3, "rc_y");
    step(R, G, R, 0, 0, 1, 6, 4, "red_clear");
    clear_and_restart(8'd4, "c6");

    step(X, R, R, 0, 1, 0, 0, 4, "invalid1");
    step(X, R, R, 0, 0, 1, 2, 5, "invalid2");
    clear_and_restart(8'd5, "c2");

    step(R, R, G, 0, 1, 0, 0, 5, "ped1");
    step(R, R, G, 0, 0, 1, 3, 6, "ped2");
    clear_and_restart(8'd6, "c3");

    // Asynchronous reset in the middle of a fault.
    step(G, R, R, 0, 1, 0, 0, 6, "pre_rst_g");
    step(R, R, R, 0, 0, 1, 4, 7, "pre_rst_fault");
    @(negedge clk);
    #2;
    push(0, 0, 0, 0, "async_reset");
    reset = 1'b0;
    -> chk_ev;
    repeat (2) @(posedge clk);
    release_and_start("restart");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
